// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the packet bus controllers.
// Imported by the transfer controller and its arbiters.
package bus_ctrl_pkg;

  localparam int ID_W = 8;

  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
  localparam logic [ID_W-1:0] DROP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    DEC,
    PUSH
  } bus_state_e;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority request picker: first set bit
// strictly after ptr, searched circularly.
module rr_picker
  import bus_ctrl_pkg::*;
#(
  parameter int drvrs = 4
) (
  input  logic [drvrs-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             valid
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  logic [IW-1:0] j;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_idx = '0;
    valid   = 1'b0;
    j       = '0;
    for (int k = drvrs; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % drvrs);
      if (req[j]) begin
        gnt_idx = ID_W'(j);
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_ctrl.sv
// Round-robin transfer controller for the shared packet bus:
// pop one source, decode its header, push to dest or broadcast.
module bus_rr_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = BCAST_ID
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  input  logic [drvrs-1:0]         full,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id,
  output logic [ID_W-1:0]          drop_cnt
);

  bus_state_e state, state_nx;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_vld;
  logic [pckg_sz-1:0] pkt_r;
  logic [pckg_sz-1:0] head;
  logic [drvrs-1:0]   mask_r;
  logic [drvrs-1:0]   dec_mask;
  logic [drvrs-1:0]   pop_nx;
  logic [drvrs-1:0]   push_nx;
  logic [ID_W-1:0]    dest;
  logic               is_bc;
  logic               dec_ok;
  logic               stall;

  rr_picker #(
    .drvrs(drvrs)
  ) u_pick (
    .req    (pndng),
    .ptr    (rr_ptr),
    .gnt_idx(pick_idx),
    .valid  (pick_vld)
  );

  assign dest  = pkt_r[pckg_sz-1 -: ID_W];
  assign stall = |(full & mask_r);

  always_comb begin
    head = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (i == int'(grant_id)) begin
        head = D_pop[i*pckg_sz +: pckg_sz];
      end
    end
  end

  // Self-addressed or out-of-range unicast is a drop.
  always_comb begin
    is_bc    = (dest == broadcast);
    dec_mask = '0;
    for (int i = 0; i < drvrs; i++) begin
      dec_mask[i] = is_bc ? (i != int'(grant_id))
                          : (i == int'(dest));
    end
    dec_ok = is_bc ||
             ((int'(dest) < drvrs) &&
              (dest != grant_id));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_vld) state_nx = POP;
      POP:     state_nx = DEC;
      DEC:     state_nx = dec_ok ? PUSH : IDLE;
      PUSH:    if (!stall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    pop_nx  = '0;
    push_nx = '0;
    for (int i = 0; i < drvrs; i++) begin
      pop_nx[i] = (state == POP) &&
                  (i == int'(grant_id));
    end
    if (state == PUSH && !stall) begin
      push_nx = mask_r;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      grant_id <= '0;
      rr_ptr   <= ID_W'(drvrs - 1);
      pkt_r    <= '0;
      mask_r   <= '0;
      drop_cnt <= '0;
    end else begin
      pop  <= pop_nx;
      push <= push_nx;
      if (|push_nx) begin
        D_push <= pkt_r;
      end
      if (state == IDLE && pick_vld) begin
        grant_id <= pick_idx;
        rr_ptr   <= pick_idx;
      end
      if (state == POP) begin
        pkt_r <= head;
      end
      if (state == DEC) begin
        if (dec_ok) begin
          mask_r <= dec_mask;
        end else if (drop_cnt != DROP_MAX) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_rr_ctrl.sv
// Scoreboard bench for bus_rr_ctrl: queue-based FIFO and
// arbitration model, push checks in a separate monitor.
module tb_bus_rr_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   pndng;
  logic [N*W-1:0] D_pop;
  logic [N-1:0]   pop;
  logic [N-1:0]   full;
  logic [N-1:0]   push;
  logic [W-1:0]   D_push;
  logic           busy;
  logic [7:0]     grant_id;
  logic [7:0]     drop_cnt;

  bus_rr_ctrl #(
    .drvrs    (N),
    .pckg_sz  (W),
    .broadcast(8'hFF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pndng   (pndng),
    .D_pop   (D_pop),
    .pop     (pop),
    .full    (full),
    .push    (push),
    .D_push  (D_push),
    .busy    (busy),
    .grant_id(grant_id),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] mask;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  logic [W-1:0] fq[N][$];
  exp_t         sb[$];

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int pop_due = -1;
  int last_src = N - 1;
  int drop_exp = 0;
  int age = 0;
  int t_pop = 0;
  int last_push_cyc = 0;
  int pops_seen = 0;
  int bp_cnt = 0;
  int full_pct = 0;
  bit inflight = 0;
  bit bp_mode = 0;
  bit use_stuck = 0;
  logic [N-1:0] stuck = '0;
  logic [N-1:0] cur_mask;
  logic [W-1:0] cur_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    else
      passed++;
  endtask

  task automatic bad(input string nm);
    total++;
    $display("FAIL %s: bound expired at cycle %0d",
             nm, cyc);
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < N; i++)
      if (fq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int next_src();
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last_src + k) % N;
      if (fq[j].size() != 0) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_mask(
      input int src, input logic [7:0] d);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      if (d == 8'hFF) m[i] = (i != src);
      else m[i] = (int'(d) < N) && (int'(d) != src)
                  && (i == int'(d));
    end
    return m;
  endfunction

  function automatic logic [N-1:0] oh(input int s);
    logic [N-1:0] v;
    v = '0;
    if (s >= 0) v[s] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_pkt();
    int r;
    logic [7:0] d;
    r = $urandom_range(0, 9);
    if (r < 4) d = 8'(r);
    else if (r < 6) d = 8'hFF;
    else d = 8'($urandom_range(4, 254));
    return {d, 8'($urandom)};
  endfunction

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      pndng[i] = (fq[i].size() != 0);
      D_pop[i*W +: W] = pndng[i] ? fq[i][0] : '0;
    end
  endtask

  task automatic load(input int src, input logic [W-1:0] p);
    fq[src].push_back(p);
    if (pop_due < 0 && !inflight) pop_due = cyc + 2;
    refresh();
  endtask

  // One negedge: observe pop, drive full, predict push edge.
  task automatic step();
    int s;
    logic [W-1:0] p;
    logic [N-1:0] m;
    @(negedge clk);
    s = next_src();
    if (pop != 0) begin
      chk("pop_time", cyc, pop_due);
      chk("pop_port", pop, oh(s));
      chk("grant_id", grant_id, s);
      pops_seen++;
      t_pop = cyc;
      if (s >= 0) begin
        p = fq[s].pop_front();
        last_src = s;
        m = exp_mask(s, p[W-1 -: 8]);
        if (m == 0) begin
          if (drop_exp < 255) drop_exp++;
          pop_due = any_pend() ? cyc + 3 : -1;
        end else begin
          inflight = 1;
          age = 0;
          cur_mask = m;
          cur_data = p;
          pop_due = -1;
        end
      end
    end else if (pop_due >= 0 && cyc > pop_due) begin
      chk("pop_missing", pop, oh(s));
      pop_due = -1;
    end
    if (bp_mode) begin
      full = '0;
      if (inflight && age >= 1 && bp_cnt < 5) begin
        full = 4'b1000;
        bp_cnt++;
      end
    end else if (use_stuck) begin
      full = stuck;
    end else begin
      for (int i = 0; i < N; i++)
        full[i] = ($urandom_range(0, 99) < full_pct);
    end
    if (inflight) begin
      if (age >= 1 && (full & cur_mask) == 0) begin
        sb.push_back('{cur_mask, cur_data, cyc + 1});
        inflight = 0;
        pop_due = any_pend() ? cyc + 3 : -1;
      end
      age++;
    end
    refresh();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((any_pend() || inflight || pop_due >= 0 ||
            sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) bad("drain_timeout");
    repeat (3) step();
    chk("busy_idle", busy, 0);
    chk("drop_cnt", drop_cnt, drop_exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_push", push, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_pop", pop, 0);
    sb.delete();
    inflight = 0;
    pop_due = -1;
    last_src = N - 1;
    drop_exp = 0;
    for (int i = 0; i < N; i++) fq[i].delete();
    refresh();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every push must match the scoreboard head.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (push != 0) begin
      last_push_cyc = cyc;
      if (sb.size() == 0) begin
        chk("push_unexp", push, 0);
      end else begin
        e = sb.pop_front();
        chk("push_mask", push, e.mask);
        chk("push_data", D_push, e.data);
        chk("push_cycle", cyc, e.due);
      end
    end else if (sb.size() != 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      chk("push_missing", push, e.mask);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int w;
    reset = 1'b1;
    full = '0;
    refresh();
    #7;
    chk("rst_pop0", pop, 0);
    chk("rst_push0", push, 0);
    chk("rst_dpush0", D_push, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_gid0", grant_id, 0);
    chk("rst_drop0", drop_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    load(1, 16'h0202);
    drain(50);

    load(0, 16'h0211); load(0, 16'h0112);
    load(1, 16'h0321); load(1, 16'h0022);
    load(3, 16'h0031); load(3, 16'h0232);
    drain(100);

    load(2, 16'hFF55);
    drain(50);

    bp_mode = 1; bp_cnt = 0; pops_seen = 0;
    load(0, 16'h0311);
    drain(50);
    chk("bp_delay", last_push_cyc - t_pop, 7);
    chk("bp_pops", pops_seen, 1);
    bp_mode = 0;

    load(0, 16'h0700); load(0, 16'h0001);
    drain(50);
    chk("drops2", drop_cnt, 2);

    full_pct = 30;
    repeat (20) begin
      for (int p = 0; p < N; p++)
        repeat ($urandom_range(0, 3)) load(p, rnd_pkt());
      drain(2000);
    end
    full_pct = 0;

    repeat (300)
      load($urandom_range(0, N - 1),
           {8'($urandom_range(4, 254)), 8'($urandom)});
    drain(5000);
    chk("drop_sat", drop_cnt, 255);

    use_stuck = 1; stuck = 4'b1000;
    load(1, 16'h0333);
    w = 0;
    while (!(inflight && age >= 3) && w < 20) begin
      step();
      w++;
    end
    if (w >= 20) bad("reach_push");
    do_reset();
    use_stuck = 0;
    load(2, 16'h0144); load(0, 16'h0245);
    repeat (2) step();
    chk("post_reset_grant", grant_id, 0);
    drain(100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
